sme_match_collector: RTL and testbench



---
 rtl/sme_pkg.sv | 29 ++
 rtl/sme_state_fifo.sv | 62 ++++++
 rtl/sme_match_collector.sv | 148 ++++++++++++++
 tb/tb_sme_match_collector.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sme_pkg.sv
// Shared types and constants for the string-matcher match collector.
// Result slots pair a count/flags record with the packet's preamble state.
package sme_pkg;

  localparam int MAX_MATCH = 8;
  localparam int ID_W      = 32;
  localparam int CNT_W     = $clog2(MAX_MATCH + 1);
  localparam int IDX_W     = $clog2(MAX_MATCH);
  localparam int STATE_W   = 64;

  localparam logic [ID_W-1:0]  NO_MATCH_ID = '0;
  localparam logic [CNT_W-1:0] MAX_CNT     = CNT_W'(MAX_MATCH);

  // Field positions inside the preamble state word
  localparam int HAS_PREAMBLE_BIT = 60;
  localparam int IS_TCP_BIT       = 56;

  typedef struct packed {
    logic [CNT_W-1:0]   count;
    logic               ovf;
    logic               nostate;
    logic [STATE_W-1:0] state;
  } sme_result_t;

  function automatic logic id_is_match(input logic [ID_W-1:0] id);
    return (id != NO_MATCH_ID);
  endfunction

endpackage

// File: rtl/sme_state_fifo.sv
// Two-entry show-ahead FIFO for preamble states with a sticky overflow flag.
// A push while full is dropped unless a pop frees an entry in the same cycle.
module sme_state_fifo
  import sme_pkg::*;
#(
  parameter int W = STATE_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_push,
  input  logic [W-1:0] i_data,
  input  logic         i_pop,
  output logic         o_empty,
  output logic [W-1:0] o_head,
  output logic         o_ovf
);

  logic [W-1:0] r_mem [2];
  logic         r_head;
  logic         r_tail;
  logic [1:0]   r_cnt;
  logic         r_ovf;
  logic         w_full;
  logic         w_pop;
  logic         w_push;

  assign w_full  = (r_cnt == 2'd2);
  assign o_empty = (r_cnt == 2'd0);
  assign w_pop   = i_pop && !o_empty;
  assign w_push  = i_push && (!w_full || w_pop);
  assign o_head  = r_mem[r_head];
  assign o_ovf   = r_ovf;

  // Storage, pointers, occupancy and overflow flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_head   <= 1'b0;
      r_tail   <= 1'b0;
      r_cnt    <= 2'd0;
      r_ovf    <= 1'b0;
    end else begin
      if (w_push) begin
        r_mem[r_tail] <= i_data;
        r_tail        <= ~r_tail;
      end
      if (w_pop) begin
        r_head <= ~r_head;
      end
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + 2'd1;
        2'b01:   r_cnt <= r_cnt - 2'd1;
        default: r_cnt <= r_cnt;
      endcase
      if (i_push && w_full && !w_pop) begin
        r_ovf <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/sme_match_collector.sv
// Collects rule IDs per packet into a 2-slot ping-pong result buffer,
// pairing each packet with its preamble state for the core to read.
module sme_match_collector
  import sme_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic [ID_W-1:0]    match_rules_ID,
  input  logic               match_last,
  input  logic               match_valid,
  output logic               match_release,
  input  logic [STATE_W-1:0] preamble_state_out,
  input  logic               state_out_valid,
  output logic               res_valid,
  output logic [CNT_W-1:0]   res_count,
  output logic               res_ovf,
  output logic               res_nostate,
  output logic [STATE_W-1:0] res_state,
  input  logic [CNT_W-1:0]   rd_idx,
  output logic [ID_W-1:0]    rd_id,
  input  logic               res_pop,
  output logic               err_state_ovf
);

  logic [ID_W-1:0]    r_ids [2][MAX_MATCH];
  sme_result_t        r_res [2];
  logic [1:0]         r_full;
  logic               r_wr_ptr;
  logic               r_rd_ptr;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_ovf;

  logic               w_xfer;
  logic               w_close;
  logic               w_store;
  logic               w_pop_ok;
  logic [CNT_W-1:0]   w_cnt_nxt;
  logic               w_ovf_nxt;
  logic               w_fifo_empty;
  logic [STATE_W-1:0] w_fifo_head;
  logic               w_fifo_push;
  logic               w_fifo_pop;
  logic [STATE_W-1:0] w_slot_state;
  logic               w_slot_nostate;

  assign match_release = !r_full[r_wr_ptr];
  assign w_xfer        = match_valid && match_release;
  assign w_close       = w_xfer && match_last;
  assign w_pop_ok      = res_pop && r_full[r_rd_ptr];

  // When the FIFO is empty at close, a coincident state pulse goes straight to the slot
  assign w_fifo_pop  = w_close && !w_fifo_empty;
  assign w_fifo_push = state_out_valid && !(w_close && w_fifo_empty);

  sme_state_fifo #(.W(STATE_W)) u_state_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_fifo_push),
    .i_data  (preamble_state_out),
    .i_pop   (w_fifo_pop),
    .o_empty (w_fifo_empty),
    .o_head  (w_fifo_head),
    .o_ovf   (err_state_ovf)
  );

  // Fill-counter update for the beat being accepted
  always_comb begin
    w_store   = 1'b0;
    w_cnt_nxt = r_cnt;
    w_ovf_nxt = r_ovf;
    if (w_xfer && id_is_match(match_rules_ID)) begin
      if (r_cnt < MAX_CNT) begin
        w_store   = 1'b1;
        w_cnt_nxt = r_cnt + CNT_W'(1);
      end else begin
        w_ovf_nxt = 1'b1;
      end
    end else begin
      w_store = 1'b0;
    end
  end

  // State paired with the closing packet
  always_comb begin
    w_slot_state   = '0;
    w_slot_nostate = 1'b0;
    if (!w_fifo_empty) begin
      w_slot_state = w_fifo_head;
    end else if (state_out_valid) begin
      w_slot_state = preamble_state_out;
    end else begin
      w_slot_nostate = 1'b1;
    end
  end

  // Slot storage, fill state and ping-pong pointers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < 2; s++) begin
        r_res[s] <= '0;
        for (int i = 0; i < MAX_MATCH; i++) begin
          r_ids[s][i] <= '0;
        end
      end
      r_full   <= 2'b00;
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_cnt    <= '0;
      r_ovf    <= 1'b0;
    end else begin
      if (w_store) begin
        r_ids[r_wr_ptr][r_cnt[IDX_W-1:0]] <= match_rules_ID;
      end
      if (w_close) begin
        r_res[r_wr_ptr] <= '{count: w_cnt_nxt, ovf: w_ovf_nxt,
                              nostate: w_slot_nostate, state: w_slot_state};
        r_full[r_wr_ptr] <= 1'b1;
        r_wr_ptr         <= ~r_wr_ptr;
        r_cnt            <= '0;
        r_ovf            <= 1'b0;
      end else begin
        r_cnt <= w_cnt_nxt;
        r_ovf <= w_ovf_nxt;
      end
      if (w_pop_ok) begin
        r_full[r_rd_ptr] <= 1'b0;
        r_rd_ptr         <= ~r_rd_ptr;
      end
    end
  end

  assign res_valid   = r_full[r_rd_ptr];
  assign res_count   = r_res[r_rd_ptr].count;
  assign res_ovf     = r_res[r_rd_ptr].ovf;
  assign res_nostate = r_res[r_rd_ptr].nostate;
  assign res_state   = r_res[r_rd_ptr].state;

  // Combinational ID read from the read slot; out-of-range indices read as zero
  always_comb begin
    rd_id = '0;
    if (rd_idx < MAX_CNT) begin
      rd_id = r_ids[r_rd_ptr][rd_idx[IDX_W-1:0]];
    end else begin
      rd_id = '0;
    end
  end

endmodule

// File: tb/tb_sme_match_collector.sv
// Directed bench for sme_match_collector: hand-computed expectations checked
// with immediate assertions at each step.
module tb_sme_match_collector;
  import sme_pkg::*;

  logic               clk = 1'b0;
  logic               rst_n;
  logic [ID_W-1:0]    match_rules_ID;
  logic               match_last;
  logic               match_valid;
  logic               match_release;
  logic [STATE_W-1:0] preamble_state_out;
  logic               state_out_valid;
  logic               res_valid;
  logic [CNT_W-1:0]   res_count;
  logic               res_ovf;
  logic               res_nostate;
  logic [STATE_W-1:0] res_state;
  logic [CNT_W-1:0]   rd_idx;
  logic [ID_W-1:0]    rd_id;
  logic               res_pop;
  logic               err_state_ovf;

  int n_vec = 0;
  int n_err = 0;

  localparam logic [63:0] ST_A = 64'h1111_1111_1111_1111;
  localparam logic [63:0] ST_B = 64'hABCD_0123_4567_89EF;
  localparam logic [63:0] ST_C = 64'h1100_0000_0000_00AA;
  localparam logic [63:0] ST_D = 64'h0100_0000_0000_00BB;
  localparam logic [63:0] ST_E = 64'h1000_0000_0000_00CC;

  sme_match_collector dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .match_rules_ID     (match_rules_ID),
    .match_last         (match_last),
    .match_valid        (match_valid),
    .match_release      (match_release),
    .preamble_state_out (preamble_state_out),
    .state_out_valid    (state_out_valid),
    .res_valid          (res_valid),
    .res_count          (res_count),
    .res_ovf            (res_ovf),
    .res_nostate        (res_nostate),
    .res_state          (res_state),
    .rd_idx             (rd_idx),
    .rd_id              (rd_id),
    .res_pop            (res_pop),
    .err_state_ovf      (err_state_ovf)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [ID_W-1:0] id, input logic last);
    match_valid    = 1'b1;
    match_rules_ID = id;
    match_last     = last;
    tick();
    match_valid    = 1'b0;
    match_last     = 1'b0;
    match_rules_ID = '0;
  endtask

  task automatic pulse(input logic [63:0] st);
    state_out_valid    = 1'b1;
    preamble_state_out = st;
    tick();
    state_out_valid    = 1'b0;
    preamble_state_out = '0;
  endtask

  task automatic pop();
    res_pop = 1'b1;
    tick();
    res_pop = 1'b0;
  endtask

  task automatic rdchk(input string tag, input int idx, input logic [ID_W-1:0] exp);
    rd_idx = CNT_W'(idx);
    #1;
    chk(tag, 64'(rd_id), 64'(exp));
  endtask

  initial begin
    rst_n              = 1'b0;
    match_rules_ID     = '0;
    match_last         = 1'b0;
    match_valid        = 1'b0;
    preamble_state_out = '0;
    state_out_valid    = 1'b0;
    rd_idx             = '0;
    res_pop            = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_release", 64'(match_release), 64'd1);
    chk("rst_valid",   64'(res_valid),     64'd0);
    chk("rst_count",   64'(res_count),     64'd0);
    chk("rst_ovf",     64'(res_ovf),       64'd0);
    chk("rst_nostate", 64'(res_nostate),   64'd0);
    chk("rst_state",   res_state,          64'd0);
    chk("rst_errovf",  64'(err_state_ovf), 64'd0);
    rst_n = 1'b1;
    tick();

    // Basic packet with a queued state
    pulse(ST_A);
    send(32'd5, 1'b0);
    send(32'd9, 1'b0);
    chk("basic_notyet", 64'(res_valid), 64'd0);
    send(32'd12, 1'b1);
    chk("basic_valid",   64'(res_valid),   64'd1);
    chk("basic_count",   64'(res_count),   64'd3);
    chk("basic_state",   res_state,        ST_A);
    chk("basic_nostate", 64'(res_nostate), 64'd0);
    rdchk("basic_id0", 0, 32'd5);
    rdchk("basic_id1", 1, 32'd9);
    rdchk("basic_id2", 2, 32'd12);
    pop();
    chk("basic_popped", 64'(res_valid), 64'd0);

    // No-match packet, FIFO empty and no pulse
    send(NO_MATCH_ID, 1'b1);
    chk("nomatch_valid",   64'(res_valid),   64'd1);
    chk("nomatch_count",   64'(res_count),   64'd0);
    chk("nomatch_ovf",     64'(res_ovf),     64'd0);
    chk("nomatch_nostate", 64'(res_nostate), 64'd1);
    chk("nomatch_state",   res_state,        64'd0);
    pop();

    // Overflow: 10 IDs into 8 entries
    for (int i = 1; i <= 10; i++) begin
      send(32'(i), (i == 10));
    end
    chk("ovf_count", 64'(res_count), 64'd8);
    chk("ovf_flag",  64'(res_ovf),   64'd1);
    rdchk("ovf_id7", 7, 32'd8);
    pop();

    // Next packet clears overflow; close coincides with a state pulse (bypass)
    send(32'd3, 1'b0);
    match_valid        = 1'b1;
    match_rules_ID     = 32'd4;
    match_last         = 1'b1;
    state_out_valid    = 1'b1;
    preamble_state_out = ST_B;
    tick();
    match_valid        = 1'b0;
    match_last         = 1'b0;
    match_rules_ID     = '0;
    state_out_valid    = 1'b0;
    preamble_state_out = '0;
    chk("byp_ovf",     64'(res_ovf),     64'd0);
    chk("byp_count",   64'(res_count),   64'd2);
    chk("byp_state",   res_state,        ST_B);
    chk("byp_nostate", 64'(res_nostate), 64'd0);
    pop();
    send(32'd7, 1'b1);
    chk("byp_notkept", 64'(res_nostate), 64'd1);
    pop();

    // Backpressure: two closes fill both slots, third packet stalls
    send(32'd21, 1'b1);
    chk("bp_rel_1", 64'(match_release), 64'd1);
    send(32'd22, 1'b1);
    chk("bp_rel_full", 64'(match_release), 64'd0);
    match_valid    = 1'b1;
    match_rules_ID = 32'd23;
    match_last     = 1'b1;
    tick();
    tick();
    chk("bp_stall_rel", 64'(match_release), 64'd0);
    rdchk("bp_first_id", 0, 32'd21);
    res_pop = 1'b1;
    tick();
    res_pop = 1'b0;
    chk("bp_rel_rise", 64'(match_release), 64'd1);
    tick();
    match_valid    = 1'b0;
    match_last     = 1'b0;
    match_rules_ID = '0;
    chk("bp_second_valid", 64'(res_valid), 64'd1);
    rdchk("bp_second_id", 0, 32'd22);
    pop();
    chk("bp_third_valid", 64'(res_valid), 64'd1);
    chk("bp_third_count", 64'(res_count), 64'd1);
    rdchk("bp_third_id", 0, 32'd23);
    pop();
    chk("bp_drained", 64'(res_valid), 64'd0);

    // State FIFO overflow: three pulses with no closes
    pulse(ST_C);
    pulse(ST_D);
    chk("sovf_two", 64'(err_state_ovf), 64'd0);
    pulse(ST_E);
    chk("sovf_three", 64'(err_state_ovf), 64'd1);
    send(32'd30, 1'b1);
    chk("sovf_head0", res_state, ST_C);
    pop();
    send(32'd31, 1'b1);
    chk("sovf_head1", res_state, ST_D);
    pop();
    send(32'd32, 1'b1);
    chk("sovf_dropped", 64'(res_nostate), 64'd1);
    pop();

    // Async reset mid-packet with a pending result
    send(32'd39, 1'b1);
    send(32'd40, 1'b0);
    send(32'd41, 1'b0);
    chk("ar_pre_valid", 64'(res_valid), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_valid",   64'(res_valid),     64'd0);
    chk("ar_release", 64'(match_release), 64'd1);
    chk("ar_count",   64'(res_count),     64'd0);
    chk("ar_errovf",  64'(err_state_ovf), 64'd0);
    tick();
    rst_n = 1'b1;
    tick();
    send(32'd50, 1'b1);
    chk("ar_new_count", 64'(res_count), 64'd1);
    rdchk("ar_new_id", 0, 32'd50);
    pop();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
